// File: rtl/mux_sel_sequencer_if.sv
// rtl/mux_sel_sequencer_if.sv - control, mux drive and observation signals of the mux select sequencer
interface mux_sel_sequencer_if;
    logic       start;
    logic       stop;
    logic [1:0] y_in;
    logic       en_out;
    logic [1:0] s_out;
    logic       busy;
    logic       round_done;
    logic [7:0] round_cnt;
    logic [7:0] y_snap;

    // board controller / observer side
    modport master (
        output start, stop, y_in,
        input  en_out, s_out, busy, round_done, round_cnt, y_snap
    );

    // sequencer side
    modport slave (
        input  start, stop, y_in,
        output en_out, s_out, busy, round_done, round_cnt, y_snap
    );
endinterface

// File: rtl/mux_sel_sequencer.sv
// rtl/mux_sel_sequencer.sv - steps a 2-bit select mux through S=00..11 and EN toggles, snapshotting Y
module mux_sel_sequencer #(
    parameter int DWELL0 = 3,
    parameter int DWELL1 = 5,
    parameter int DWELL2 = 7,
    parameter int DWELL3 = 11,
    parameter int DWELL4 = 13,
    parameter int CW     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mux_sel_sequencer_if.slave   bus
);

    // dwell counters are loaded with DWELLk-1 so each phase lasts exactly DWELLk cycles
    localparam logic [CW-1:0] LOAD0 = CW'(DWELL0 - 1);
    localparam logic [CW-1:0] LOAD1 = CW'(DWELL1 - 1);
    localparam logic [CW-1:0] LOAD2 = CW'(DWELL2 - 1);
    localparam logic [CW-1:0] LOAD3 = CW'(DWELL3 - 1);
    localparam logic [CW-1:0] LOAD4 = CW'(DWELL4 - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P0   = 3'd1,
        P1   = 3'd2,
        P2   = 3'd3,
        P3   = 3'd4,
        P4   = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    s_q, s_d;
    logic          en_q, en_d;
    logic [7:0]    snap_q, snap_d;
    logic [7:0]    rcnt_q, rcnt_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;

    // next-state and datapath: count down the dwell, act on the last cycle of each phase
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        en_d    = en_q;
        snap_d  = snap_q;
        rcnt_d  = rcnt_q;
        done_d  = 1'b0;

        if (state_q == IDLE) begin
            // stop has priority over start; s_out/en_out are carried into the new run
            if (bus.start && !bus.stop) begin
                state_d = P0;
                cnt_d   = LOAD0;
            end
        end else if (bus.stop) begin
            // abort without performing the phase action; all outputs hold
            state_d = IDLE;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else begin
            // y_in is captured on the same edge that S moves, so it reflects the old S
            case (state_q)
                P0: begin
                    s_d     = 2'b00;
                    state_d = P1;
                    cnt_d   = LOAD1;
                end
                P1: begin
                    snap_d[1:0] = bus.y_in;
                    s_d         = 2'b01;
                    state_d     = P2;
                    cnt_d       = LOAD2;
                end
                P2: begin
                    snap_d[3:2] = bus.y_in;
                    s_d         = 2'b10;
                    state_d     = P3;
                    cnt_d       = LOAD3;
                end
                P3: begin
                    snap_d[5:4] = bus.y_in;
                    s_d         = 2'b11;
                    state_d     = P4;
                    cnt_d       = LOAD4;
                end
                P4: begin
                    snap_d[7:6] = bus.y_in;
                    en_d        = ~en_q;
                    rcnt_d      = rcnt_q + 8'd1;
                    done_d      = 1'b1;
                    state_d     = P0;
                    cnt_d       = LOAD0;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // state and output registers; synchronous reset overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            s_q     <= 2'b00;
            en_q    <= 1'b0;
            snap_q  <= 8'h00;
            rcnt_q  <= 8'h00;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            en_q    <= en_d;
            snap_q  <= snap_d;
            rcnt_q  <= rcnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.s_out      = s_q;
    assign bus.en_out     = en_q;
    assign bus.y_snap     = snap_q;
    assign bus.round_cnt  = rcnt_q;
    assign bus.round_done = done_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// tb/tb_mux_sel_sequencer.sv - directed self-checking bench for mux_sel_sequencer
module tb_mux_sel_sequencer;

    logic       clk;
    logic       rst;
    logic       y_mode;
    logic [1:0] y_const;
    int         n_tests;
    int         n_fail;

    mux_sel_sequencer_if bus();

    assign bus.y_in = y_mode ? ~bus.s_out : y_const;

    mux_sel_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.stop  = 1'b0;
        tick();
        tick();
        n_tests++; if (bus.s_out !== 2'b00) begin n_fail++; $display("FAIL reset_s_out got %b exp 00", bus.s_out); end
        n_tests++; if (bus.en_out !== 1'b0) begin n_fail++; $display("FAIL reset_en_out got %b exp 0", bus.en_out); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        n_tests++; if (bus.round_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_round_cnt got %h exp 00", bus.round_cnt); end
        n_tests++; if (bus.y_snap !== 8'h00) begin n_fail++; $display("FAIL reset_y_snap got %h exp 00", bus.y_snap); end
        n_tests++; if (bus.round_done !== 1'b0) begin n_fail++; $display("FAIL reset_round_done got %b exp 0", bus.round_done); end
        bus.start = 1'b0;
        rst       = 1'b0;
    endtask

    // one full round from reset; optional start pulses while busy must not disturb timing
    task automatic run_round_timing(input bit pulses);
        logic [1:0] exp_s;
        logic       exp_en;
        logic       exp_rd;
        apply_reset();
        y_mode    = 1'b0;
        y_const   = 2'b00;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL timing_busy_E0 got %b exp 1", bus.busy); end
        for (int e = 1; e <= 42; e++) begin
            bus.start = (pulses && (e == 10 || e == 30)) ? 1'b1 : 1'b0;
            tick();
            exp_s  = (e < 8) ? 2'b00 : (e < 15) ? 2'b01 : (e < 26) ? 2'b10 : (e < 42) ? 2'b11 : 2'b00;
            exp_en = (e >= 39);
            exp_rd = (e == 39);
            n_tests++; if (bus.s_out !== exp_s) begin n_fail++; $display("FAIL timing_s_out E%0d got %b exp %b", e, bus.s_out, exp_s); end
            n_tests++; if (bus.en_out !== exp_en) begin n_fail++; $display("FAIL timing_en_out E%0d got %b exp %b", e, bus.en_out, exp_en); end
            n_tests++; if (bus.round_done !== exp_rd) begin n_fail++; $display("FAIL timing_round_done E%0d got %b exp %b", e, bus.round_done, exp_rd); end
            n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL timing_busy E%0d got %b exp 1", e, bus.busy); end
        end
        bus.start = 1'b0;
        n_tests++; if (bus.round_cnt !== 8'd1) begin n_fail++; $display("FAIL timing_round_cnt got %0d exp 1", bus.round_cnt); end
    endtask

    task automatic test_sequence();
        run_round_timing(1'b0);
    endtask

    task automatic test_snapshot();
        apply_reset();
        y_mode    = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int e = 1; e <= 39; e++) tick();
        n_tests++; if (bus.y_snap !== 8'h1B) begin n_fail++; $display("FAIL snap_inverted got %h exp 1b", bus.y_snap); end
        apply_reset();
        y_mode    = 1'b0;
        y_const   = 2'b10;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int e = 1; e <= 39; e++) tick();
        n_tests++; if (bus.y_snap !== 8'hAA) begin n_fail++; $display("FAIL snap_const got %h exp aa", bus.y_snap); end
    endtask

    task automatic test_stop_restart();
        logic [1:0] exp_s;
        apply_reset();
        y_mode    = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int e = 1; e <= 19; e++) tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL stop_busy got %b exp 0", bus.busy); end
        n_tests++; if (bus.s_out !== 2'b10) begin n_fail++; $display("FAIL stop_s_out got %b exp 10", bus.s_out); end
        n_tests++; if (bus.en_out !== 1'b0) begin n_fail++; $display("FAIL stop_en_out got %b exp 0", bus.en_out); end
        n_tests++; if (bus.y_snap !== 8'h0B) begin n_fail++; $display("FAIL stop_y_snap got %h exp 0b", bus.y_snap); end
        n_tests++; if (bus.round_cnt !== 8'd0) begin n_fail++; $display("FAIL stop_round_cnt got %0d exp 0", bus.round_cnt); end
        for (int e = 21; e <= 24; e++) begin
            tick();
            n_tests++; if (bus.busy !== 1'b0 || bus.s_out !== 2'b10) begin n_fail++; $display("FAIL stop_hold E%0d busy %b s %b exp 0 10", e, bus.busy, bus.s_out); end
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy got %b exp 1", bus.busy); end
        for (int e = 26; e <= 33; e++) begin
            tick();
            exp_s = (e < 28) ? 2'b10 : (e < 33) ? 2'b00 : 2'b01;
            n_tests++; if (bus.s_out !== exp_s) begin n_fail++; $display("FAIL restart_s_out E%0d got %b exp %b", e, bus.s_out, exp_s); end
        end
    endtask

    task automatic test_start_stop_priority();
        apply_reset();
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        for (int e = 0; e < 3; e++) begin
            tick();
            n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL both_high_busy cycle %0d got %b exp 0", e, bus.busy); end
        end
        bus.start = 1'b0;
        bus.stop  = 1'b1;
        tick();
        bus.stop = 1'b0;
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL stop_idle_busy got %b exp 0", bus.busy); end
        run_round_timing(1'b1);
    endtask

    task automatic test_reset_mid_round();
        apply_reset();
        y_mode    = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int e = 1; e <= 34; e++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b exp 0", bus.busy); end
        n_tests++; if (bus.s_out !== 2'b00) begin n_fail++; $display("FAIL midrst_s_out got %b exp 00", bus.s_out); end
        n_tests++; if (bus.en_out !== 1'b0) begin n_fail++; $display("FAIL midrst_en_out got %b exp 0", bus.en_out); end
        n_tests++; if (bus.y_snap !== 8'h00) begin n_fail++; $display("FAIL midrst_y_snap got %h exp 00", bus.y_snap); end
        n_tests++; if (bus.round_cnt !== 8'd0) begin n_fail++; $display("FAIL midrst_round_cnt got %0d exp 0", bus.round_cnt); end
        for (int e = 0; e < 8; e++) begin
            tick();
            n_tests++; if (bus.en_out !== 1'b0 || bus.busy !== 1'b0 || bus.round_done !== 1'b0) begin n_fail++; $display("FAIL midrst_quiet cycle %0d en %b busy %b done %b exp 0 0 0", e, bus.en_out, bus.busy, bus.round_done); end
        end
    endtask

    task automatic test_wrap();
        int rd_count;
        apply_reset();
        y_mode    = 1'b1;
        rd_count  = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int e = 1; e <= 256 * 39; e++) begin
            tick();
            if (bus.round_done === 1'b1) rd_count++;
            if (e == 255 * 39) begin
                n_tests++; if (bus.round_cnt !== 8'd255) begin n_fail++; $display("FAIL wrap_cnt_255 got %0d exp 255", bus.round_cnt); end
                n_tests++; if (bus.en_out !== 1'b1) begin n_fail++; $display("FAIL wrap_en_255 got %b exp 1", bus.en_out); end
            end
        end
        n_tests++; if (bus.round_cnt !== 8'd0) begin n_fail++; $display("FAIL wrap_cnt got %0d exp 0", bus.round_cnt); end
        n_tests++; if (bus.en_out !== 1'b0) begin n_fail++; $display("FAIL wrap_en got %b exp 0", bus.en_out); end
        n_tests++; if (rd_count != 256) begin n_fail++; $display("FAIL wrap_round_done_pulses got %0d exp 256", rd_count); end
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL wrap_busy got %b exp 1", bus.busy); end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        y_mode    = 1'b0;
        y_const   = 2'b00;
        test_reset();
        test_sequence();
        test_snapshot();
        test_stop_restart();
        test_start_stop_priority();
        test_reset_mid_round();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
